// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM-stage memory request and the single-port dm.
// Optional macro STORE_FWD_EN forwards a buffered word store to a word load instead of stalling.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          req_valid,
   input  logic          req_we,
   input  logic [2:0]    req_type,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic [31:0]   req_rdata,
   output logic          stall,
   output logic          dm_we,
   output logic [2:0]    dm_type,
   output logic [31:0]   dm_addr,
   output logic [31:0]   dm_wdata,
   input  logic [31:0]   dm_rdata,
   output logic          sb_empty,
   output logic [AW:0]   sb_count
);
   localparam logic [2:0] DM_WORD = 3'b000;

   logic [2:0]    type_q [DEPTH];
   logic [31:0]   addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [AW:0]   count_q, count_d;
   logic          is_load_s, is_store_s, hit_s, fwd_s, claim_s, pop_s;
`ifdef STORE_FWD_EN
   logic [2:0]    young_type_s;
   logic [31:0]   young_data_s;
`endif

   assign is_load_s  = req_valid & ~req_we;
   assign is_store_s = req_valid & req_we;

   // Scan oldest to youngest so the last word-address match seen is the youngest one
   always_comb begin
      hit_s = 1'b0;
`ifdef STORE_FWD_EN
      young_type_s = DM_WORD;
      young_data_s = 32'h0000_0000;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         if (((AW+1)'(k) < count_q) && (addr_q[head_q + AW'(k)][31:2] == req_addr[31:2])) begin
            hit_s = 1'b1;
`ifdef STORE_FWD_EN
            young_type_s = type_q[head_q + AW'(k)];
            young_data_s = data_q[head_q + AW'(k)];
`endif
         end else begin
            hit_s = hit_s;
         end
      end
   end

`ifdef STORE_FWD_EN
   assign fwd_s = is_load_s & hit_s & (young_type_s == DM_WORD) & (req_type == DM_WORD);
`else
   assign fwd_s = 1'b0;
`endif
   assign claim_s = is_load_s & ~hit_s;
   assign pop_s   = ~claim_s & (count_q != {(AW+1){1'b0}});
   assign stall   = is_load_s & hit_s & ~fwd_s;

   // dm port and load result: drain head, or serve a non-hitting load, or idle
   always_comb begin
      dm_we     = 1'b0;
      dm_type   = DM_WORD;
      dm_addr   = 32'h0000_0000;
      dm_wdata  = 32'h0000_0000;
      req_rdata = 32'h0000_0000;
      if (pop_s) begin
         dm_we    = 1'b1;
         dm_type  = type_q[head_q];
         dm_addr  = addr_q[head_q];
         dm_wdata = data_q[head_q];
      end else if (claim_s) begin
         dm_type = req_type;
         dm_addr = req_addr;
      end else begin
         dm_we = 1'b0;
      end
      if (claim_s) begin
         req_rdata = dm_rdata;
`ifdef STORE_FWD_EN
      end else if (fwd_s) begin
         req_rdata = young_data_s;
`endif
      end else begin
         req_rdata = 32'h0000_0000;
      end
   end

   // Pointer and occupancy next state; a push and a pop together leave count unchanged
   always_comb begin
      head_d  = pop_s ? (head_q + AW'(1)) : head_q;
      tail_d  = is_store_s ? (tail_q + AW'(1)) : tail_q;
      case ({is_store_s, pop_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q  <= {AW{1'b0}};
         tail_q  <= {AW{1'b0}};
         count_q <= {(AW+1){1'b0}};
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage needs no reset; only entries inside count are ever read
   always_ff @(posedge clk) begin
      if (is_store_s) begin
         type_q[tail_q] <= req_type;
         addr_q[tail_q] <= req_addr;
         data_q[tail_q] <= req_wdata;
      end
   end

   assign sb_empty = (count_q == {(AW+1){1'b0}});
   assign sb_count = count_q;

endmodule
